// File: rtl/trdb_packet_sequencer.sv
// trdb_packet_sequencer
//   Builds the lc/tc/nc instruction context from a one-step-per-beat stream,
//   owns the resync counter and thaddr state, and selects the packet
//   format/subformat and payload mux controls. Decisions are queued in a small
//   FIFO drained by the packet emitter over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i + step attrs    one instruction step (becomes tc on acceptance)
//   enc_*/opmode_change_i   support-event pulses, held until the next decision
//   flush_i                 decide pending tc with an unqualified nc
//   resync_mode_i/max_i     resync counting mode and threshold
//   pkt_*_o, pkt_ready_i    FIFO head and emitter handshake
//   packets_lost_o          sticky loss flag
//   fifo_level_o            FIFO occupancy
module trdb_packet_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RESYNC_W   = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             valid_i,
    input  logic                             qualified_i,
    input  logic                             exception_i,
    input  logic                             retired_i,
    input  logic                             privchange_i,
    input  logic                             context_change_i,
    input  logic                             updiscon_i,
    input  logic                             branch_map_empty_i,
    input  logic                             branch_map_full_i,
    input  logic                             enc_enabled_i,
    input  logic                             enc_disabled_i,
    input  logic                             opmode_change_i,
    input  logic                             flush_i,
    input  logic                             resync_mode_i,
    input  logic [RESYNC_W-1:0]              resync_max_i,
    output logic                             pkt_valid_o,
    input  logic                             pkt_ready_i,
    output logic [1:0]                       pkt_format_o,
    output logic [1:0]                       pkt_subformat_o,
    output logic                             pkt_thaddr_o,
    output logic                             pkt_cause_sel_o,
    output logic                             pkt_tval_sel_o,
    output logic                             packets_lost_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);

    localparam logic [1:0] F_OPT_EXT    = 2'd0;
    localparam logic [1:0] F_DIFF_DELTA = 2'd1;
    localparam logic [1:0] F_ADDR_ONLY  = 2'd2;
    localparam logic [1:0] F_SYNC       = 2'd3;
    localparam logic [1:0] SF_START     = 2'd0;
    localparam logic [1:0] SF_TRAP      = 2'd1;
    localparam logic [1:0] SF_SUPPORT   = 2'd3;

    typedef struct packed {
        logic q;
        logic exc;
        logic ret;
        logic priv;
        logic ctx;
        logic upd;
        logic bm_empty;
        logic bm_full;
    } step_t;

    typedef struct packed {
        logic [1:0] fmt;
        logic [1:0] sub;
        logic       thaddr;
        logic       cause_sel;
        logic       tval_sel;
    } pkt_t;

    // state
    step_t                tc_q, tc_d, lc_q, lc_d;
    logic                 tc_v_q, tc_v_d, lc_v_q, lc_v_d;
    logic                 thaddr_q, thaddr_d;
    logic [RESYNC_W-1:0]  cnt_q, cnt_d;
    logic                 lost_q, lost_d;
    logic                 ev_q, ev_d;
    pkt_t                 mem_q [FIFO_DEPTH];
    pkt_t                 mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;

    // decision terms
    step_t  in_step, nc;
    logic   dec_ev, ev_any, first_q, final_q, reported, resync_hit;
    logic   tc_exc_only, tc_er, tc_ppccd, nc_exc_only, nc_ppccd;
    logic [1:0] f12;
    logic   match;
    pkt_t   dec_pkt;
    logic   pop, full, push_req, push_ok, cnt_clr, cnt_inc;

    assign in_step = '{q: qualified_i, exc: exception_i, ret: retired_i,
                       priv: privchange_i, ctx: context_change_i, upd: updiscon_i,
                       bm_empty: branch_map_empty_i, bm_full: branch_map_full_i};

    // A flush presents an all-zero (unqualified) nc.
    assign nc          = valid_i ? in_step : '0;
    assign dec_ev      = (valid_i | flush_i) & tc_v_q;
    assign ev_any      = ev_q | enc_enabled_i | enc_disabled_i | opmode_change_i;
    assign first_q     = tc_q.q & ~(lc_v_q & lc_q.q);
    assign final_q     = lc_v_q & lc_q.q & ~tc_q.q;
    assign tc_exc_only = tc_q.exc & ~tc_q.ret;
    assign tc_er       = tc_q.exc & tc_q.ret;
    assign tc_ppccd    = tc_q.priv | tc_q.ctx;
    assign nc_exc_only = nc.exc & ~nc.ret;
    assign nc_ppccd    = nc.priv | nc.ctx;
    assign reported    = lc_q.exc & ~thaddr_q;
    assign resync_hit  = cnt_q >= resync_max_i;
    assign f12         = tc_q.bm_empty ? F_ADDR_ONLY : F_DIFF_DELTA;

    // Format selection, first match wins.
    always_comb begin
        match   = 1'b0;
        dec_pkt = '{fmt: F_OPT_EXT, sub: SF_START, thaddr: 1'b0,
                    cause_sel: 1'b0, tval_sel: 1'b0};
        if (ev_any | final_q | lost_q) begin
            match       = 1'b1;
            dec_pkt.fmt = F_SYNC;
            dec_pkt.sub = SF_SUPPORT;
        end else if (tc_q.q & lc_q.exc) begin
            match       = 1'b1;
            dec_pkt.fmt = F_SYNC;
            if (tc_exc_only) begin
                dec_pkt.sub = SF_TRAP;
            end else if (reported) begin
                dec_pkt.sub = SF_START;
            end else begin
                dec_pkt.sub    = SF_TRAP;
                dec_pkt.thaddr = 1'b1;
            end
        end else if (tc_q.q & (first_q | tc_ppccd | resync_hit)) begin
            match       = 1'b1;
            dec_pkt.fmt = F_SYNC;
        end else if (tc_q.q & lc_q.upd) begin
            match = 1'b1;
            if (tc_exc_only) begin
                dec_pkt.fmt       = F_SYNC;
                dec_pkt.sub       = SF_TRAP;
                dec_pkt.cause_sel = 1'b1;
                dec_pkt.tval_sel  = 1'b1;
            end else begin
                dec_pkt.fmt = f12;
            end
        end else if (tc_q.q & ((resync_hit & ~tc_q.bm_empty) | tc_er)) begin
            match       = 1'b1;
            dec_pkt.fmt = f12;
        end else if (tc_q.q & (nc_exc_only | (nc_ppccd & ~nc.bm_empty) | ~nc.q)) begin
            match       = 1'b1;
            dec_pkt.fmt = f12;
        end else if (tc_q.q & tc_q.bm_full) begin
            match       = 1'b1;
            dec_pkt.fmt = F_DIFF_DELTA;
        end
    end

    // FIFO control: a push into a full FIFO survives only if the head pops
    // on the same edge.
    assign pop      = (level_q != '0) & pkt_ready_i;
    assign full     = level_q == LW'(FIFO_DEPTH);
    assign push_req = dec_ev & match;
    assign push_ok  = push_req & (~full | pop);

    // Resync clears on START/TRAP (F1/F2 share subformat code 0, so gate on F_SYNC).
    assign cnt_clr = push_ok & (dec_pkt.fmt == F_SYNC) &
                     ((dec_pkt.sub == SF_START) | (dec_pkt.sub == SF_TRAP));
    assign cnt_inc = resync_mode_i ? push_ok : valid_i;

    always_comb begin
        tc_d     = tc_q;
        lc_d     = lc_q;
        tc_v_d   = tc_v_q;
        lc_v_d   = lc_v_q;
        thaddr_d = thaddr_q;
        cnt_d    = cnt_q;
        lost_d   = lost_q;
        ev_d     = dec_ev ? 1'b0 : ev_any;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // valid_i outranks flush_i
        if (valid_i) begin
            lc_d   = tc_q;
            lc_v_d = tc_v_q;
            tc_d   = in_step;
            tc_v_d = 1'b1;
        end else if (flush_i) begin
            lc_d   = tc_q;
            lc_v_d = tc_v_q;
            tc_v_d = 1'b0;
        end

        if (dec_ev) thaddr_d = dec_pkt.thaddr;

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && cnt_q != '1) begin
            cnt_d = cnt_q + RESYNC_W'(1);
        end

        if (push_req & ~push_ok) begin
            lost_d = 1'b1;
        end else if (push_ok & (dec_pkt.fmt == F_SYNC) & (dec_pkt.sub == SF_SUPPORT)) begin
            lost_d = 1'b0;
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = dec_pkt;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        level_d = level_q + LW'(push_ok) - LW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tc_q     <= '0;
            lc_q     <= '0;
            tc_v_q   <= 1'b0;
            lc_v_q   <= 1'b0;
            thaddr_q <= 1'b0;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
            ev_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            tc_q     <= tc_d;
            lc_q     <= lc_d;
            tc_v_q   <= tc_v_d;
            lc_v_q   <= lc_v_d;
            thaddr_q <= thaddr_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            ev_q     <= ev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    pkt_t head;
    assign head            = mem_q[rd_ptr_q];
    assign pkt_valid_o     = level_q != '0;
    assign pkt_format_o    = pkt_valid_o ? head.fmt       : 2'd0;
    assign pkt_subformat_o = pkt_valid_o ? head.sub       : 2'd0;
    assign pkt_thaddr_o    = pkt_valid_o & head.thaddr;
    assign pkt_cause_sel_o = pkt_valid_o & head.cause_sel;
    assign pkt_tval_sel_o  = pkt_valid_o & head.tval_sel;
    assign packets_lost_o  = lost_q;
    assign fifo_level_o    = level_q;

endmodule

// File: tb/tb_trdb_packet_sequencer.sv
// Directed bench for trdb_packet_sequencer. Each stimulus row is applied for
// one clock; the FIFO head is then sampled 1 time unit after the edge and
// compared against a hand-computed packet code
// {valid, format, subformat, thaddr, cause_sel, tval_sel}.
module tb_trdb_packet_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, q = 1'b0, exc = 1'b0, ret = 1'b0, priv = 1'b0, ctx = 1'b0;
    logic        upd = 1'b0, bme = 1'b0, bmf = 1'b0;
    logic        enc_en = 1'b0, enc_dis = 1'b0, opm = 1'b0, flush = 1'b0;
    logic        rmode = 1'b0;
    logic [15:0] rmax = 16'd1000;
    logic        ready = 1'b1;
    logic        pvalid, pth, pcs, pts, lost;
    logic [1:0]  pfmt, psub;
    logic [2:0]  level;
    logic [7:0]  head;

    int errors = 0;
    int checks = 0;

    trdb_packet_sequencer #(.FIFO_DEPTH(4), .RESYNC_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid),
        .qualified_i(q), .exception_i(exc), .retired_i(ret), .privchange_i(priv),
        .context_change_i(ctx), .updiscon_i(upd), .branch_map_empty_i(bme),
        .branch_map_full_i(bmf), .enc_enabled_i(enc_en), .enc_disabled_i(enc_dis),
        .opmode_change_i(opm), .flush_i(flush), .resync_mode_i(rmode),
        .resync_max_i(rmax), .pkt_valid_o(pvalid), .pkt_ready_i(ready),
        .pkt_format_o(pfmt), .pkt_subformat_o(psub), .pkt_thaddr_o(pth),
        .pkt_cause_sel_o(pcs), .pkt_tval_sel_o(pts), .packets_lost_o(lost),
        .fifo_level_o(level)
    );

    always #5 clk = ~clk;

    assign head = {pvalid, pfmt, psub, pth, pcs, pts};

    // step codes {q, exc, ret, priv, ctx, upd, bm_empty, bm_full}
    localparam logic [7:0] PLAIN    = 8'b1000_0010;
    localparam logic [7:0] PLAIN_BM = 8'b1000_0000;
    localparam logic [7:0] EXC_ONLY = 8'b1100_0010;
    localparam logic [7:0] ER_BM    = 8'b1110_0000;
    localparam logic [7:0] UPD      = 8'b1000_0110;
    localparam logic [7:0] UNQ      = 8'b0000_0010;

    // packet codes {valid, fmt, sub, thaddr, cause_sel, tval_sel}
    localparam logic [7:0] NONE    = 8'b0_00_00_000;
    localparam logic [7:0] START   = 8'b1_11_00_000;
    localparam logic [7:0] SUPPORT = 8'b1_11_11_000;
    localparam logic [7:0] TRAP_LC = 8'b1_11_01_000;
    localparam logic [7:0] TRAP_TC = 8'b1_11_01_011;
    localparam logic [7:0] ADDR    = 8'b1_10_00_000;
    localparam logic [7:0] DIFF    = 8'b1_01_00_000;

    // row kinds
    localparam int K_STEP  = 0;
    localparam int K_FLUSH = 1;
    localparam int K_IDLE  = 2;
    localparam int K_SF    = 3;  // step and flush together
    localparam int K_ENC   = 4;  // step with enc_enabled pulse
    localparam int K_OPM   = 5;  // idle with opmode_change pulse

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", pvalid, 0);
        chk("rst_head", head, NONE);
        chk("rst_level", level, 0);
        chk("rst_lost", lost, 0);
        rst = 1'b0;
    endtask

    task automatic apply(input int kind, input logic [7:0] code);
        valid  = (kind == K_STEP) || (kind == K_SF) || (kind == K_ENC);
        flush  = (kind == K_FLUSH) || (kind == K_SF);
        enc_en = (kind == K_ENC);
        opm    = (kind == K_OPM);
        {q, exc, ret, priv, ctx, upd, bme, bmf} = valid ? code : 8'h00;
        tick();
        {valid, flush, enc_en, opm, q, exc, ret, priv, ctx, upd, bme, bmf} = '0;
    endtask

    task automatic row(input string tag, input int kind, input logic [7:0] code,
                       input logic [7:0] exp);
        apply(kind, code);
        chk(tag, head, exp);
    endtask

    initial begin
        // ---------------- start-up and exception/trap ----------------
        do_reset();
        row("su_e1",  K_STEP, PLAIN,    NONE);
        row("su_e2",  K_STEP, PLAIN,    START);
        row("su_e3",  K_STEP, PLAIN,    NONE);
        row("ex_e4",  K_STEP, EXC_ONLY, ADDR);
        row("ex_e5",  K_STEP, EXC_ONLY, ADDR);
        row("ex_trap_lc", K_STEP, PLAIN, TRAP_LC);
        row("ex_reported", K_STEP, ER_BM, START);
        row("ex_er_diff", K_STEP, PLAIN, DIFF);
        row("ex_e9",  K_STEP, UPD,      START);
        row("ex_e10", K_STEP, EXC_ONLY, ADDR);
        row("ex_trap_tc", K_STEP, PLAIN, TRAP_TC);
        row("ex_e12", K_STEP, PLAIN,    START);
        row("ex_e13", K_STEP, PLAIN,    NONE);

        // ---------------- resync, mode 0, threshold 5 ----------------
        rmax = 16'd5;
        do_reset();
        row("rs_e1", K_STEP, PLAIN, NONE);
        row("rs_e2", K_STEP, PLAIN, START);
        for (int e = 3; e <= 14; e++) begin
            row($sformatf("rs_e%0d", e), K_STEP, PLAIN,
                (e == 8 || e == 14) ? START : NONE);
        end
        rmax = 16'd1000;

        // ---------------- flush, valid+flush, support events ----------------
        do_reset();
        row("fl_e1",  K_STEP,  PLAIN,    NONE);
        row("fl_e2",  K_STEP,  PLAIN,    START);
        row("fl_addr", K_FLUSH, 8'h00,   ADDR);
        row("fl_empty", K_FLUSH, 8'h00,  NONE);
        row("fl_e5",  K_STEP,  PLAIN_BM, NONE);
        row("fl_e6",  K_STEP,  PLAIN_BM, START);
        row("fl_diff", K_FLUSH, 8'h00,   DIFF);
        row("fl_sf",  K_SF,    PLAIN,    NONE);
        row("fl_sf_next", K_STEP, PLAIN, START);
        row("sp_enc", K_ENC,   PLAIN,    SUPPORT);
        row("sp_consumed", K_STEP, PLAIN, NONE);
        row("sp_e12", K_FLUSH, 8'h00,    ADDR);
        row("sp_opm_idle", K_OPM, 8'h00, NONE);
        row("sp_e14", K_STEP,  PLAIN,    NONE);
        row("sp_latched", K_STEP, PLAIN, SUPPORT);
        row("sp_e16", K_STEP,  UNQ,      ADDR);
        row("sp_final", K_STEP, PLAIN,   SUPPORT);

        // ---------------- backpressure overflow ----------------
        ready = 1'b0;
        do_reset();
        row("ov_e1", K_STEP, PLAIN, NONE);
        row("ov_e2", K_STEP, UNQ,   START);
        row("ov_e3", K_STEP, PLAIN, START);
        row("ov_e4", K_STEP, UNQ,   START);
        row("ov_e5", K_STEP, PLAIN, START);
        chk("ov_level4", level, 4);
        chk("ov_nolost", lost, 0);
        row("ov_drop", K_STEP, UNQ, START);
        chk("ov_level_full", level, 4);
        chk("ov_lost", lost, 1);
        row("ov_hold", K_IDLE, 8'h00, START);
        chk("ov_lost_hold", lost, 1);
        ready = 1'b1;
        row("ov_release", K_STEP, PLAIN, SUPPORT);
        chk("ov_level_after", level, 4);
        chk("ov_lost_clr", lost, 0);
        row("ov_d1", K_IDLE, 8'h00, START);
        row("ov_d2", K_IDLE, 8'h00, SUPPORT);
        row("ov_d3", K_IDLE, 8'h00, SUPPORT);
        chk("ov_level1", level, 1);
        row("ov_d4", K_IDLE, 8'h00, NONE);
        chk("ov_level0", level, 0);

        // ---------------- reset mid-operation ----------------
        ready = 1'b0;
        do_reset();
        row("mr_e1", K_STEP, PLAIN, NONE);
        row("mr_e2", K_STEP, UNQ,   START);
        row("mr_e3", K_STEP, PLAIN, START);
        chk("mr_level2", level, 2);
        rst = 1'b1;
        tick();
        chk("mr_valid", pvalid, 0);
        chk("mr_level", level, 0);
        rst = 1'b0;
        ready = 1'b1;
        row("mr_e5", K_STEP, PLAIN, NONE);
        row("mr_e6", K_STEP, PLAIN, START);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
